// File: rtl/bounce_pkg.sv
// Shared types and constants for the contact-bounce emulator.
// Holds the FSM state, the LFSR feedback mask and the saturating glitch counter helper.
package bounce_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    BOUNCE = 1'b1
  } state_e;

  localparam logic [15:0] LFSR_TAPS = 16'hB400;
  localparam int          GLITCH_W  = 8;
  localparam logic [GLITCH_W-1:0] GLITCH_MAX = '1;

  // Adds one toggle to a glitch tally, sticking at the all-ones ceiling.
  function automatic logic [GLITCH_W-1:0] sat_inc(input logic [GLITCH_W-1:0] v,
                                                  input logic               inc);
    return (inc && (v != GLITCH_MAX)) ? v + GLITCH_W'(1) : v;
  endfunction

endpackage

// File: rtl/lfsr16.sv
// Free-running 16-bit Galois LFSR used as the bounce noise source.
// A zero seed would lock the register at zero, so it is promoted to 1.
module lfsr16
  import bounce_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] seed,
  output logic [15:0] q
);

  logic [15:0] w_seed;
  logic [15:0] r_q;

  assign w_seed = (seed == 16'h0000) ? 16'h0001 : seed;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q <= w_seed;
    end else begin
      r_q <= r_q[0] ? ((r_q >> 1) ^ LFSR_TAPS) : (r_q >> 1);
    end
  end

  assign q = r_q;

endmodule

// File: rtl/bounce_gen.sv
// Switch-bounce emulator: turns each clean level change into BOUNCE_CYCLES edges of
// LFSR noise before settling, and reports how many times the output toggled.
module bounce_gen
  import bounce_pkg::*;
#(
  parameter int unsigned BOUNCE_CYCLES = 64,
  parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                enable,
  input  logic                clean_in,
  output logic                bounce_out,
  output logic                busy,
  output logic                done,
  output logic [GLITCH_W-1:0] glitch_count
);

  localparam logic [15:0] CNT_LOAD = 16'(BOUNCE_CYCLES - 1);

  state_e              r_state, w_state_nxt;
  logic                r_level, w_level_nxt;
  logic                r_target, w_target_nxt;
  logic [15:0]         r_cnt, w_cnt_nxt;
  logic                r_bounce, w_bounce_nxt;
  logic [GLITCH_W-1:0] r_acc, w_acc_nxt;
  logic                r_done, w_done_nxt;
  logic [GLITCH_W-1:0] r_gc, w_gc_nxt;
  logic                w_noise;
  logic [14:0]         w_lfsr_unused;

  lfsr16 u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .seed  (LFSR_SEED),
    .q     ({w_lfsr_unused, w_noise})
  );

  // NOTE: every next value defaults to its current register first, so no path infers a latch.
  always_comb begin
    w_state_nxt  = r_state;
    w_level_nxt  = r_level;
    w_target_nxt = r_target;
    w_cnt_nxt    = r_cnt;
    w_bounce_nxt = r_bounce;
    w_acc_nxt    = r_acc;
    w_done_nxt   = 1'b0;
    w_gc_nxt     = r_gc;

    if (!enable) begin
      w_state_nxt  = IDLE;
      w_bounce_nxt = clean_in;
      w_level_nxt  = clean_in;
    end else begin
      case (r_state)
        IDLE: begin
          if (clean_in != r_level) begin
            w_state_nxt  = BOUNCE;
            w_target_nxt = clean_in;
            w_cnt_nxt    = CNT_LOAD;
            w_bounce_nxt = ~r_level;
            w_acc_nxt    = GLITCH_W'(1);
          end
        end
        BOUNCE: begin
          // A new clean level wins over settling, even on the last counted edge.
          if (clean_in != r_target) begin
            w_target_nxt = clean_in;
            w_cnt_nxt    = CNT_LOAD;
            w_bounce_nxt = w_noise;
          end else if (r_cnt == '0) begin
            w_state_nxt  = IDLE;
            w_bounce_nxt = r_target;
            w_level_nxt  = r_target;
            w_done_nxt   = 1'b1;
            w_gc_nxt     = sat_inc(r_acc, r_target != r_bounce);
          end else begin
            w_bounce_nxt = w_noise;
            w_cnt_nxt    = r_cnt - 16'd1;
            w_acc_nxt    = sat_inc(r_acc, w_noise != r_bounce);
          end
        end
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  // NOTE: registers update with non-blocking assignments so every next value is computed from pre-edge state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_level  <= 1'b0;
      r_target <= 1'b0;
      r_cnt    <= '0;
      r_bounce <= 1'b0;
      r_acc    <= '0;
      r_done   <= 1'b0;
      r_gc     <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_level  <= w_level_nxt;
      r_target <= w_target_nxt;
      r_cnt    <= w_cnt_nxt;
      r_bounce <= w_bounce_nxt;
      r_acc    <= w_acc_nxt;
      r_done   <= w_done_nxt;
      r_gc     <= w_gc_nxt;
    end
  end

  assign bounce_out   = r_bounce;
  assign busy         = (r_state == BOUNCE);
  assign done         = r_done;
  assign glitch_count = r_gc;

endmodule

// File: doc/bounce_gen.md
BOUNCE_GEN -- requirements
Module: bounce_gen

Interface
REQ-001 Parameter BOUNCE_CYCLES, default 64, means the number of clock cycles of emulated contact bounce per clean edge; legal range 1..65535.
REQ-002 Parameter LFSR_SEED, default 16'hACE1, means the 16-bit LFSR reset value; 16'h0000 is replaced by 16'h0001.
REQ-003 clk  input  1  means the single system clock; all logic is on its rising edge.
REQ-004 rst_n  input  1  means the reset, asynchronous and active-low.
REQ-005 enable  input  1  means 1 = emulate bounce, 0 = bypass.
REQ-006 clean_in  input  1  means the ideal switch level, synchronous to clk.
REQ-007 bounce_out  output  1  means the emulated noisy switch contact, registered.
REQ-008 busy  output  1  means high while in BOUNCE state.
REQ-009 done  output  1  means a one-cycle pulse when bounce_out settles after an event.
REQ-010 glitch_count  output  8  means the bounce_out toggles in the last completed event, saturating at 255.

Function
REQ-011 State machine SHALL have states IDLE and BOUNCE; internal registers level_q (settled level), target, cnt (16 bit), toggle accumulator (8 bit).
REQ-012 LFSR SHALL be 16-bit Galois with taps mask 16'hB400, advancing every clock regardless of state; bounce noise bit = lfsr[0].
REQ-013 IDLE, enable=1, clean_in != level_q at edge k: state<=BOUNCE, target<=clean_in, cnt<=BOUNCE_CYCLES-1, bounce_out<=~level_q (first edge always toggles), accumulator<=1.
REQ-014 BOUNCE, clean_in == target, cnt != 0: bounce_out<=lfsr[0], cnt<=cnt-1, accumulator += (lfsr[0] != bounce_out), saturating at 255.
REQ-015 BOUNCE, cnt == 0: bounce_out<=target, level_q<=target, state<=IDLE, done<=1 for one cycle, glitch_count<=final accumulator including this edge's toggle, saturating.
REQ-016 Settling latency SHALL be exactly BOUNCE_CYCLES edges: an edge detected at k leaves bounce_out == target from edge k+BOUNCE_CYCLES onward.
REQ-017 Restart: BOUNCE with clean_in != target SHALL set target<=clean_in, cnt<=BOUNCE_CYCLES-1, bounce_out<=lfsr[0], and keep the accumulator; restart has priority over the cnt==0 finalize.
REQ-018 enable=0 in any state SHALL set bounce_out<=clean_in, level_q<=clean_in, state<=IDLE; no done pulse; glitch_count unchanged.
REQ-019 busy SHALL be combinationally (state == BOUNCE).
REQ-020 BOUNCE_CYCLES=1 SHALL give a single-cycle toggle to target, then done at edge k+1.

Reset
REQ-021 rst_n low SHALL force state=IDLE, bounce_out=0, level_q=0, target=0, cnt=0, done=0, glitch_count=0, accumulator=0, lfsr=LFSR_SEED (or 1), asynchronously.
REQ-022 Reset deassertion mid-operation SHALL resume from IDLE; if clean_in=1, a fresh event starts on the first edge.

Structure
REQ-023 Shared package bounce_pkg SHALL hold the state enum (IDLE, BOUNCE), LFSR_TAPS = 16'hB400, and the glitch-count width constant 8.
REQ-024 The LFSR SHALL be the sub-module lfsr16 (clk, rst_n, seed, q[15:0]), instantiated once.

Verification
REQ-025 Reset applied -> bounce_out=0, busy=0, done=0, glitch_count=0 while rst_n=0 and the first cycle after release.
REQ-026 BOUNCE_CYCLES=16, clean_in 0->1 sampled at edge k -> bounce_out=1 at k, busy=1 k..k+15, done=1 only at k+16, bounce_out=1 from k+16, glitch_count equals bench-counted toggles.
REQ-027 BOUNCE_CYCLES=16, clean_in 0->1 at k then 1->0 at k+5 -> no done before k+21, bounce_out=0 from k+21, done at k+21.
REQ-028 enable=0 with clean_in toggling every 3 cycles -> bounce_out equals clean_in delayed 1 cycle, busy=0, done never asserts; enable dropped mid-bounce -> IDLE next edge.
REQ-029 rst_n pulsed low at k+4 of a BOUNCE_CYCLES=16 event -> outputs at reset values immediately, no done pulse, lfsr reloaded; LFSR_SEED=0 -> lfsr never stuck at 0.
REQ-030 Loopback bounce_gen.bounce_out -> debounce.data_in, BOUNCE_CYCLES=200, clean_in 0->1 -> data_debounced=1 after exactly 65535 stable cycles past settle, no intermediate glitch.
